// File: rtl/clock_bcd_counter_if.sv
// Control inputs and BCD time outputs of the clock timekeeping core.
// master drives run/buttons and observes the display digits; slave is the counter.
interface clock_bcd_counter_if;
    logic       run;
    logic       inc_min;
    logic       inc_hour;
    logic [3:0] hour_h;
    logic [3:0] hour_l;
    logic [3:0] min_h;
    logic [3:0] min_l;
    logic [3:0] sec_h;
    logic [3:0] sec_l;
    logic       tick_1hz;
    logic       hour_pulse;

    modport master (
        output run, inc_min, inc_hour,
        input  hour_h, hour_l, min_h, min_l, sec_h, sec_l, tick_1hz, hour_pulse
    );

    modport slave (
        input  run, inc_min, inc_hour,
        output hour_h, hour_l, min_h, min_l, sec_h, sec_l, tick_1hz, hour_pulse
    );
endinterface

// File: rtl/clock_bcd_counter.sv
// 24-hour HH:MM:SS BCD timekeeper with 1 Hz prescaler, run/hold and button adjust.
// Latency: all outputs registered, digits change one edge after tick condition or button edge.
// No backpressure: run=0 freezes prescaler and seconds; buttons always accepted.
module clock_bcd_counter #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    clock_bcd_counter_if.slave   bus
);
    localparam int           CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] presc, presc_nxt;
    logic [3:0]    hh, hl, mh, ml, sh, sl;
    logic [3:0]    hh_nxt, hl_nxt, mh_nxt, ml_nxt, sh_nxt, sl_nxt;
    logic          tick_q, tick_nxt, hp_q, hp_nxt;
    logic          min_prev, hour_prev;

    logic          min_edge, hour_edge, adj, tick_cond, do_tick;
    logic [4:0]    sl_inc, sh_inc, ml_inc, mh_inc;
    logic [3:0]    mh_step, ml_step, hh_step, hl_step;
    logic          sec_roll, min_roll, hour_top;

    // Saturating compare against the digit limit keeps any digit from leaving its range.
    function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic [3:0] top);
        if (d >= top)
            bcd_inc = {1'b1, 4'd0};
        else
            bcd_inc = {1'b0, d + 4'd1};
    endfunction

    always_comb begin
        min_edge  = bus.inc_min & ~min_prev;
        hour_edge = bus.inc_hour & ~hour_prev;
        adj       = min_edge | hour_edge;
        tick_cond = bus.run && (presc == LAST);
        do_tick   = tick_cond && !adj;

        sl_inc   = bcd_inc(sl, 4'd9);
        sh_inc   = bcd_inc(sh, 4'd5);
        ml_inc   = bcd_inc(ml, 4'd9);
        mh_inc   = bcd_inc(mh, 4'd5);
        sec_roll = sl_inc[4] & sh_inc[4];
        min_roll = ml_inc[4] & mh_inc[4];

        ml_step  = ml_inc[3:0];
        mh_step  = ml_inc[4] ? mh_inc[3:0] : mh;

        hour_top = (hh > 4'd2) || ((hh == 4'd2) && (hl >= 4'd3));
        if (hour_top) begin
            hh_step = 4'd0;
            hl_step = 4'd0;
        end else if (hl >= 4'd9) begin
            hh_step = hh + 4'd1;
            hl_step = 4'd0;
        end else begin
            hh_step = hh;
            hl_step = hl + 4'd1;
        end

        hh_nxt   = hh;
        hl_nxt   = hl;
        mh_nxt   = mh;
        ml_nxt   = ml;
        sh_nxt   = sh;
        sl_nxt   = sl;
        tick_nxt = do_tick;
        hp_nxt   = 1'b0;

        if (do_tick) begin
            sl_nxt = sl_inc[3:0];
            if (sl_inc[4])
                sh_nxt = sh_inc[3:0];
            if (sec_roll) begin
                ml_nxt = ml_step;
                mh_nxt = mh_step;
                if (min_roll) begin
                    hh_nxt = hh_step;
                    hl_nxt = hl_step;
                    hp_nxt = 1'b1;
                end
            end
        end

        // Minute adjust never carries into hours; hour adjust is independent.
        if (min_edge) begin
            sl_nxt = 4'd0;
            sh_nxt = 4'd0;
            ml_nxt = ml_step;
            mh_nxt = mh_step;
        end
        if (hour_edge) begin
            hh_nxt = hh_step;
            hl_nxt = hl_step;
        end

        if (min_edge || tick_cond)
            presc_nxt = '0;
        else if (bus.run)
            presc_nxt = presc + CW'(1);
        else
            presc_nxt = presc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc     <= '0;
            hh        <= 4'd0;
            hl        <= 4'd0;
            mh        <= 4'd0;
            ml        <= 4'd0;
            sh        <= 4'd0;
            sl        <= 4'd0;
            tick_q    <= 1'b0;
            hp_q      <= 1'b0;
            min_prev  <= 1'b1;
            hour_prev <= 1'b1;
        end else begin
            presc     <= presc_nxt;
            hh        <= hh_nxt;
            hl        <= hl_nxt;
            mh        <= mh_nxt;
            ml        <= ml_nxt;
            sh        <= sh_nxt;
            sl        <= sl_nxt;
            tick_q    <= tick_nxt;
            hp_q      <= hp_nxt;
            min_prev  <= bus.inc_min;
            hour_prev <= bus.inc_hour;
        end
    end

    assign bus.hour_h     = hh;
    assign bus.hour_l     = hl;
    assign bus.min_h      = mh;
    assign bus.min_l      = ml;
    assign bus.sec_h      = sh;
    assign bus.sec_l      = sl;
    assign bus.tick_1hz   = tick_q;
    assign bus.hour_pulse = hp_q;
endmodule

// File: tb/tb_clock_bcd_counter.sv
// Directed bench for clock_bcd_counter: seconds-of-day reference model checked every
// cycle, plus literal expectations at the scenario milestones.
module tb_clock_bcd_counter;
    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clock_bcd_counter_if bus();

    clock_bcd_counter #(.CLK_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int hp_cnt      = 0;
    bit cmp_en      = 1'b0;

    // Reference model: time kept as seconds since midnight.
    int m_secs = 0, m_cnt = 0;
    bit m_tick = 0, m_hp = 0, m_pm = 1, m_ph = 1;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_secs = 0; m_cnt = 0; m_tick = 0; m_hp = 0; m_pm = 1; m_ph = 1;
        end else begin
            bit me, he, tc;
            int h, m, s;
            me = bus.inc_min && !m_pm;
            he = bus.inc_hour && !m_ph;
            tc = bus.run && (m_cnt == DIV - 1);
            m_tick = 0;
            m_hp   = 0;
            if (me || he) begin
                h = m_secs / 3600;
                m = (m_secs / 60) % 60;
                s = m_secs % 60;
                if (me) begin m = (m + 1) % 60; s = 0; end
                if (he) h = (h + 1) % 24;
                m_secs = h * 3600 + m * 60 + s;
            end else if (tc) begin
                m_secs = (m_secs + 1) % 86400;
                m_tick = 1;
                m_hp   = (m_secs % 3600) == 0;
            end
            if (me || tc)      m_cnt = 0;
            else if (bus.run)  m_cnt = m_cnt + 1;
            m_pm = bus.inc_min;
            m_ph = bus.inc_hour;
        end
    end

    function automatic logic [25:0] model_out();
        int h, m, s;
        h = m_secs / 3600;
        m = (m_secs / 60) % 60;
        s = m_secs % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
                4'(s / 10), 4'(s % 10), m_tick, m_hp};
    endfunction

    wire [23:0] digits = {bus.hour_h, bus.hour_l, bus.min_h, bus.min_l, bus.sec_h, bus.sec_l};
    wire [25:0] dut_out = {digits, bus.tick_1hz, bus.hour_pulse};

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [25:0] exp;
            exp = model_out();
            vectors++;
            if (dut_out !== exp) begin
                miscompares++;
                $display("FAIL cycle_model t=%0t got %h expected %h", $time, dut_out, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
            if (bus.hour_pulse) hp_cnt++;
        end while (!bus.tick_1hz && cycles < 40);
        if (!bus.tick_1hz) begin
            vectors++;
            miscompares++;
            $display("FAIL tick_timeout got no tick after %0d cycles", cycles);
        end
    endtask

    task automatic wait_ticks(input int n);
        int c;
        repeat (n) wait_tick(c);
    endtask

    task automatic press_min();
        bus.inc_min = 1'b1; @(negedge clk);
        bus.inc_min = 1'b0; @(negedge clk);
    endtask

    task automatic press_hour();
        bus.inc_hour = 1'b1; @(negedge clk);
        bus.inc_hour = 1'b0; @(negedge clk);
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        bus.run = 1'b0; bus.inc_min = 1'b0; bus.inc_hour = 1'b0;
        @(posedge clk);
        cmp_en = 1'b1;
        cyc(3);
        chk("reset_digits", 32'(digits), 32'h000000);
        chk("reset_pulses", 32'({bus.tick_1hz, bus.hour_pulse}), 32'd0);

        // Count from reset: tick every DIV cycles, sec_l steps 1..9,0.
        rst_n = 1'b1; bus.run = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            wait_tick(c);
            chk("tick_period", 32'(c), 32'(DIV));
            chk("sec_l_seq", 32'(bus.sec_l), 32'(i % 10));
        end
        chk("ten_seconds", 32'(digits), 32'h000010);

        // Hold mid-second for 20 cycles, then finish the remaining count.
        cyc(2);
        bus.run = 1'b0;
        cyc(20);
        chk("hold_digits", 32'(digits), 32'h000010);
        bus.run = 1'b1;
        wait_tick(c);
        chk("resume_remaining", 32'(c), 32'd2);
        chk("resume_digits", 32'(digits), 32'h000011);

        // Held minute button gives one increment and clears seconds.
        wait_ticks(26);
        chk("at_37", 32'(digits), 32'h000037);
        bus.run = 1'b0;
        bus.inc_min = 1'b1;
        cyc(10);
        chk("min_held", 32'(digits), 32'h000100);
        bus.inc_min = 1'b0;
        cyc(1);
        repeat (58) press_min();
        chk("min_59", 32'(digits), 32'h005900);
        repeat (60) press_min();
        chk("min_wrap60", 32'(digits), 32'h005900);
        repeat (12) press_hour();
        chk("hour_12", 32'(digits), 32'h125900);
        repeat (12) press_hour();
        chk("hour_wrap24", 32'(digits), 32'h005900);

        // Day rollover from 23:59:00.
        repeat (23) press_hour();
        chk("preload_2359", 32'(digits), 32'h235900);
        bus.run = 1'b1;
        hp_cnt = 0;
        wait_ticks(59);
        chk("at_235959", 32'(digits), 32'h235959);
        wait_tick(c);
        chk("midnight", 32'(digits), 32'h000000);
        chk("midnight_hp", 32'(bus.hour_pulse), 32'd1);
        chk("hp_once", 32'(hp_cnt), 32'd1);

        // Both buttons rise in the tick cycle at 09:59:58.
        bus.run = 1'b0;
        cyc(1);
        repeat (9) press_hour();
        repeat (59) press_min();
        bus.run = 1'b1;
        wait_ticks(58);
        chk("at_095958", 32'(digits), 32'h095958);
        cyc(DIV - 1);
        bus.inc_min = 1'b1; bus.inc_hour = 1'b1;
        @(negedge clk);
        chk("collide_digits", 32'(digits), 32'h100000);
        chk("collide_pulses", 32'({bus.tick_1hz, bus.hour_pulse}), 32'd0);
        bus.run = 1'b0; bus.inc_min = 1'b0; bus.inc_hour = 1'b0;
        cyc(1);

        // Reset during tick pulse at 12:34:56 with a button held through release.
        repeat (2) press_hour();
        repeat (34) press_min();
        bus.run = 1'b1;
        wait_ticks(56);
        chk("at_123456", 32'(digits), 32'h123456);
        rst_n = 1'b0; bus.inc_min = 1'b1;
        @(negedge clk);
        chk("rst_digits", 32'(digits), 32'h000000);
        chk("rst_pulses", 32'({bus.tick_1hz, bus.hour_pulse}), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(DIV + 2);
        chk("held_through_reset", 32'(digits), 32'h000001);
        bus.inc_min = 1'b0;
        cyc(2);

        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/clock_bcd_counter.md
# clock_bcd_counter

Timekeeping core of the clock: divides the system clock to a 1 Hz tick and maintains hours, minutes and seconds as six packed BCD digits (HH:MM:SS, 24-hour). Sits directly upstream of the two-digit BCD-to-7-segment decoders; each high/low digit pair (hour_h/hour_l, min_h/min_l, sec_h/sec_l) feeds one decoder instance's qh/ql inputs. Supports run/hold and manual minute/hour adjust from debounced buttons.

## Interface
- CLK_DIV, 50_000_000: clk cycles per 1 Hz tick; legal range ≥ 2.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset (sampled on clk rising edge).
- run  input  1  1 = timekeeping advances; 0 = hold (prescaler and seconds frozen).
- inc_min  input  1  debounced, clk-synchronous button; rising edge = minute +1.
- inc_hour  input  1  debounced, clk-synchronous button; rising edge = hour +1.
- hour_h  output  4  hours tens digit, 0–2.
- hour_l  output  4  hours units digit, 0–9 (0–3 when hour_h = 2).
- min_h  output  4  minutes tens, 0–5.
- min_l  output  4  minutes units, 0–9.
- sec_h  output  4  seconds tens, 0–5.
- sec_l  output  4  seconds units, 0–9.
- tick_1hz  output  1  one-cycle pulse, high in the cycle the new second value is first visible.
- hour_pulse  output  1  one-cycle pulse on counted hour rollover (xx:59:59 → next hour).

## Operation
- Reset (rst_n = 0 at an edge): all digits 0 (00:00:00), prescaler 0, tick_1hz = 0, hour_pulse = 0, edge-detect history registers = 1 (a button held through reset never registers).
- Prescaler: counts 0..CLK_DIV-1 while run = 1; tick condition = (count == CLK_DIV-1 && run); wraps to 0 on tick. run = 0 holds count at current value (resumes, does not restart).
- Second advance on tick: sec_l +1; 9 → 0 with carry to sec_h; sec_h 5 with carry → 0, carry to minutes. Minutes identical (59 → 00, carry to hours). Hours: 09 → 10, 19 → 20, 23 → 00.
- hour_pulse asserted only for carries from minutes into hours via ticks, including 23:59:59 → 00:00:00.
- Edge detect: edge = inc_x & ~inc_x_prev; prev updated every cycle.
- inc_min edge: minutes +1 mod 60, no carry into hours; seconds forced to 00; prescaler cleared to 0.
- inc_hour edge: hours +1 mod 24 (23 → 00); minutes, seconds, prescaler untouched.
- Both edges same cycle: both adjustments applied.
- Priority: any adjust edge in a cycle suppresses that cycle's tick (second not advanced, tick_1hz and hour_pulse stay 0); prescaler wraps/clears normally.
- Adjust never asserts tick_1hz or hour_pulse. Adjust works regardless of run.
- Digits are always legal BCD in range; no state can produce values outside listed ranges.

## Timing
- All outputs registered; no combinational path input → output.
- Tick: digit update at the edge where tick condition is true; tick_1hz high for exactly the following cycle, coincident with new digits. hour_pulse same cycle as tick_1hz.
- First tick after reset release with run = 1: CLK_DIV cycles after the first non-reset edge.
- Button: rising edge of inc_x sampled at edge N → digits changed after edge N (1-cycle latency); holding the button high gives exactly one increment.
- Reset mid-count or mid-pulse: next edge with rst_n = 0 restores reset values, dropping any pending pulse.

## Test plan
- Reset/count, CLK_DIV = 4: release reset, run = 1 → tick_1hz every 4 cycles; after 10 ticks digits 00:00:10, sec_l sequence 1..9,0 with sec_h → 1.
- Rollover: preload via adjusts to 23:59, run 60 ticks → 23:59:59 then 00:00:00; hour_pulse exactly once, same cycle as tick_1hz.
- Hold: run = 0 for 20 cycles mid-second → digits and prescaler frozen; resume completes remaining count, no extra or lost tick.
- Adjust: inc_min held high 10 cycles at 00:00:37 → 00:01:00, one increment only; 60 presses from 00:59 → 00:59 with hours unchanged; inc_hour ×24 → hours return to 00.
- Collision: inc_min and inc_hour rise in the tick cycle at 09:59:58 → 10:00:00, tick_1hz = 0, hour_pulse = 0.
- Reset mid-operation: assert rst_n = 0 during tick_1hz high at 12:34:56 with button held → next cycle 00:00:00, pulses 0; button held through release causes no increment.
